// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command frame parser.
// The CHK state exists only when UART_CMD_CHKSUM_EN is defined.
package uart_cmd_pkg;

  localparam logic [7:0] HEADER      = 8'hAA;
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CHKSUM  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

`ifdef UART_CMD_CHKSUM_EN
  typedef enum logic [2:0] {IDLE, ADDR, DHI, DLO, CHK} state_t;
`else
  typedef enum logic [1:0] {IDLE, ADDR, DHI, DLO} state_t;
`endif

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout counter: cleared by an accepted byte, counts while a frame is open,
// and flags expiry when it has sat at TIMEOUT_CYC-1.
module uart_cmd_timeout #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] count;

  // Saturate at LAST so a stalled counter can never wrap back to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || !run) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + 1'b1;
    end
  end

  assign expired = run && (count == LAST);

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses AA/addr/data_hi/data_lo[/chk] byte frames into register write commands.
// Define UART_CMD_CHKSUM_EN to add the trailing XOR checksum byte and its check.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic        RST_clk,
  input  logic        RST_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  cmd_addr,
  output logic [15:0] cmd_data,
  output logic        cmd_valid,
  output logic        cmd_err,
  output logic [1:0]  err_code,
  output logic        busy
);

  state_t      state, state_next;
  logic [7:0]  frame_addr, frame_addr_next;
  logic [7:0]  frame_dhi, frame_dhi_next;
`ifdef UART_CMD_CHKSUM_EN
  logic [7:0]  frame_dlo, frame_dlo_next;
`endif
  logic [7:0]  cmd_addr_next;
  logic [15:0] cmd_data_next;
  logic        cmd_valid_next;
  logic        cmd_err_next;
  logic [1:0]  err_code_next;
  logic        expired;

  uart_cmd_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk     (RST_clk),
    .rst     (RST_n),
    .clear   (rx_valid),
    .run     (state != IDLE),
    .expired (expired)
  );

  always_ff @(posedge RST_clk or posedge RST_n) begin
    if (RST_n) begin
      state      <= IDLE;
      frame_addr <= '0;
      frame_dhi  <= '0;
`ifdef UART_CMD_CHKSUM_EN
      frame_dlo  <= '0;
`endif
      cmd_addr   <= '0;
      cmd_data   <= '0;
      cmd_valid  <= 1'b0;
      cmd_err    <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      state      <= state_next;
      frame_addr <= frame_addr_next;
      frame_dhi  <= frame_dhi_next;
`ifdef UART_CMD_CHKSUM_EN
      frame_dlo  <= frame_dlo_next;
`endif
      cmd_addr   <= cmd_addr_next;
      cmd_data   <= cmd_data_next;
      cmd_valid  <= cmd_valid_next;
      cmd_err    <= cmd_err_next;
      err_code   <= err_code_next;
    end
  end

  always_comb begin
    state_next      = state;
    frame_addr_next = frame_addr;
    frame_dhi_next  = frame_dhi;
`ifdef UART_CMD_CHKSUM_EN
    frame_dlo_next  = frame_dlo;
`endif
    cmd_addr_next   = cmd_addr;
    cmd_data_next   = cmd_data;
    cmd_valid_next  = 1'b0;
    cmd_err_next    = 1'b0;
    err_code_next   = err_code;

    case (state)
      IDLE: if (rx_valid && rx_data == HEADER) state_next = ADDR;
      ADDR: if (rx_valid) begin
        frame_addr_next = rx_data;
        state_next      = DHI;
      end
      DHI: if (rx_valid) begin
        frame_dhi_next = rx_data;
        state_next     = DLO;
      end
`ifdef UART_CMD_CHKSUM_EN
      DLO: if (rx_valid) begin
        frame_dlo_next = rx_data;
        state_next     = CHK;
      end
      CHK: if (rx_valid) begin
        state_next = IDLE;
        if (rx_data == (frame_addr ^ frame_dhi ^ frame_dlo)) begin
          cmd_addr_next  = frame_addr;
          cmd_data_next  = {frame_dhi, frame_dlo};
          cmd_valid_next = 1'b1;
        end else begin
          cmd_err_next  = 1'b1;
          err_code_next = ERR_CHKSUM;
        end
      end
`else
      DLO: if (rx_valid) begin
        cmd_addr_next  = frame_addr;
        cmd_data_next  = {frame_dhi, rx_data};
        cmd_valid_next = 1'b1;
        state_next     = IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase

    // A byte arriving on the expiry cycle takes priority over the timeout.
    if (expired && !rx_valid) begin
      state_next    = IDLE;
      cmd_err_next  = 1'b1;
      err_code_next = ERR_TIMEOUT;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed self-checking bench for uart_cmd_parser (TIMEOUT_CYC=16); follows UART_CMD_CHKSUM_EN.
module tb_uart_cmd_parser;

  localparam int TO = 16;

  logic        RST_clk = 1'b0;
  logic        RST_n   = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_err;
  logic [1:0]  err_code;
  logic        busy;

  int errors = 0;
  int checks = 0;
  logic both_seen = 1'b0;

  uart_cmd_parser #(.TIMEOUT_CYC(TO)) dut (
    .RST_clk   (RST_clk),
    .RST_n     (RST_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .cmd_valid (cmd_valid),
    .cmd_err   (cmd_err),
    .err_code  (err_code),
    .busy      (busy)
  );

  always #5 RST_clk = ~RST_clk;

  always @(negedge RST_clk) if (cmd_valid && cmd_err) both_seen = 1'b1;

  task automatic tick();
    @(posedge RST_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] hi,
                            input logic [7:0] lo, input logic [7:0] ck);
    send_byte(8'hAA);
    send_byte(a);
    send_byte(hi);
`ifdef UART_CMD_CHKSUM_EN
    send_byte(lo);
    send_byte(ck);
`else
    send_byte(lo);
    if (ck === 8'hxx) $display("unused chk");
`endif
    $display("frame addr=%02h data=%02h%02h chk=%02h -> valid=%b err=%b code=%b",
             a, hi, lo, ck, cmd_valid, cmd_err, err_code);
  endtask

  task automatic test_reset();
    RST_n = 1'b1;
    tick(); tick();
    checks++; if (cmd_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got=%h exp=00", cmd_addr); end
    checks++; if (cmd_data !== 16'h0000) begin errors++; $display("FAIL reset_data got=%h exp=0000", cmd_data); end
    checks++; if (cmd_valid !== 1'b0 || cmd_err !== 1'b0) begin errors++; $display("FAIL reset_pulses got=%b%b exp=00", cmd_valid, cmd_err); end
    checks++; if (err_code !== 2'b00) begin errors++; $display("FAIL reset_code got=%b exp=00", err_code); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    RST_n = 1'b0;
    tick();
  endtask

  task automatic test_good_frame();
    send_frame(8'h12, 8'h34, 8'h56, 8'h70);
    checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL good_valid got=%b exp=1", cmd_valid); end
    checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL good_err got=%b exp=0", cmd_err); end
    checks++; if (cmd_addr !== 8'h12) begin errors++; $display("FAIL good_addr got=%h exp=12", cmd_addr); end
    checks++; if (cmd_data !== 16'h3456) begin errors++; $display("FAIL good_data got=%h exp=3456", cmd_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL good_busy got=%b exp=0", busy); end
    tick();
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL good_pulse_width got=%b exp=0", cmd_valid); end
  endtask

  task automatic test_bad_chksum();
`ifdef UART_CMD_CHKSUM_EN
    send_frame(8'h12, 8'h34, 8'h56, 8'h71);
    checks++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL chk_err got=%b exp=1", cmd_err); end
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL chk_valid got=%b exp=0", cmd_valid); end
    checks++; if (err_code !== 2'b01) begin errors++; $display("FAIL chk_code got=%b exp=01", err_code); end
    checks++; if (cmd_addr !== 8'h12 || cmd_data !== 16'h3456) begin errors++; $display("FAIL chk_keep got=%h/%h exp=12/3456", cmd_addr, cmd_data); end
    tick();
    checks++; if (cmd_err !== 1'b0 || err_code !== 2'b01) begin errors++; $display("FAIL chk_hold got=%b/%b exp=0/01", cmd_err, err_code); end
`endif
  endtask

  task automatic test_junk_lead();
    send_byte(8'h55);
    checks++; if (cmd_err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL junk55 got err=%b busy=%b exp=0/0", cmd_err, busy); end
    send_byte(8'h00);
    checks++; if (cmd_err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL junk00 got err=%b busy=%b exp=0/0", cmd_err, busy); end
    send_frame(8'h01, 8'h02, 8'h03, 8'h00);
    checks++; if (cmd_valid !== 1'b1 || cmd_addr !== 8'h01 || cmd_data !== 16'h0203) begin
      errors++; $display("FAIL junk_frame got v=%b %h/%h exp=1 01/0203", cmd_valid, cmd_addr, cmd_data); end
    tick();
  endtask

  task automatic test_timeout();
    int early = 0;
    send_byte(8'hAA);
    send_byte(8'h12);
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      if (cmd_err !== 1'b0 || busy !== 1'b1) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL timeout_early got=%0d premature cycles exp=0", early); end
    tick();
    checks++; if (cmd_err !== 1'b1 || cmd_valid !== 1'b0) begin errors++; $display("FAIL timeout_err got err=%b valid=%b exp=1/0", cmd_err, cmd_valid); end
    checks++; if (err_code !== 2'b10) begin errors++; $display("FAIL timeout_code got=%b exp=10", err_code); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got=%b exp=0", busy); end
    $display("timeout after %0d idle cycles -> err=%b code=%b", TO, cmd_err, err_code);
    send_frame(8'h0A, 8'h0B, 8'h0C, 8'h0D);
    checks++; if (cmd_valid !== 1'b1 || cmd_addr !== 8'h0A || cmd_data !== 16'h0B0C) begin
      errors++; $display("FAIL timeout_recover got v=%b %h/%h exp=1 0A/0B0C", cmd_valid, cmd_addr, cmd_data); end
    tick();
  endtask

  task automatic test_timeout_boundary();
    send_byte(8'hAA);
    send_byte(8'h77);
    for (int i = 0; i < TO - 1; i++) tick();
    send_byte(8'h88);
    checks++; if (cmd_err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL boundary_byte_wins got err=%b busy=%b exp=0/1", cmd_err, busy); end
`ifdef UART_CMD_CHKSUM_EN
    send_byte(8'h99);
    send_byte(8'h66);
`else
    send_byte(8'h99);
`endif
    $display("boundary frame 77 8899 -> valid=%b", cmd_valid);
    checks++; if (cmd_valid !== 1'b1 || cmd_addr !== 8'h77 || cmd_data !== 16'h8899) begin
      errors++; $display("FAIL boundary_frame got v=%b %h/%h exp=1 77/8899", cmd_valid, cmd_addr, cmd_data); end
    tick();
  endtask

  task automatic test_reset_midframe();
    int pulses = 0;
    send_byte(8'hAA);
    send_byte(8'h12);
    send_byte(8'h34);
    RST_n = 1'b1;
    #2;
    checks++; if (busy !== 1'b0 || cmd_valid !== 1'b0 || cmd_err !== 1'b0) begin
      errors++; $display("FAIL midreset_state got busy=%b v=%b e=%b exp=0/0/0", busy, cmd_valid, cmd_err); end
    tick();
    RST_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (cmd_valid !== 1'b0 || cmd_err !== 1'b0 || busy !== 1'b0) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL midreset_pulses got=%0d exp=0", pulses); end
    send_frame(8'hAB, 8'hCD, 8'hEF, 8'h89);
    checks++; if (cmd_valid !== 1'b1 || cmd_addr !== 8'hAB || cmd_data !== 16'hCDEF) begin
      errors++; $display("FAIL midreset_frame got v=%b %h/%h exp=1 AB/CDEF", cmd_valid, cmd_addr, cmd_data); end
    tick();
  endtask

  task automatic test_back_to_back();
    send_frame(8'h21, 8'h43, 8'h65, 8'h07);
    checks++; if (cmd_valid !== 1'b1 || cmd_addr !== 8'h21 || cmd_data !== 16'h4365) begin
      errors++; $display("FAIL b2b_first got v=%b %h/%h exp=1 21/4365", cmd_valid, cmd_addr, cmd_data); end
    send_frame(8'h7F, 8'hAA, 8'h00, 8'hD5);
    checks++; if (cmd_valid !== 1'b1 || cmd_addr !== 8'h7F || cmd_data !== 16'hAA00) begin
      errors++; $display("FAIL b2b_second got v=%b %h/%h exp=1 7F/AA00", cmd_valid, cmd_addr, cmd_data); end
    tick();
  endtask

  task automatic test_exclusive();
    checks++; if (both_seen !== 1'b0) begin errors++; $display("FAIL valid_err_overlap got=%b exp=0", both_seen); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_chksum();
    test_junk_lead();
    test_timeout();
    test_timeout_boundary();
    test_reset_midframe();
    test_back_to_back();
    test_exclusive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 100000, max clock cycles allowed between bytes of one frame.
REQ-002 SHALL have port RST_clk, input, 1, system clock; every register is clocked on its rising edge.
REQ-003 SHALL have port RST_n, input, 1, asynchronous active-high reset (asserted = 1) despite the port name.
REQ-004 SHALL have port rx_data, input, 8, received UART byte.
REQ-005 SHALL have port rx_valid, input, 1, one-cycle strobe in RST_clk domain qualifying rx_data.
REQ-006 SHALL have port cmd_addr, output, 8, register address of the last good frame.
REQ-007 SHALL have port cmd_data, output, 16, register data of the last good frame (hi byte first on the wire).
REQ-008 SHALL have port cmd_valid, output, 1, one-cycle pulse when cmd_addr/cmd_data update.
REQ-009 SHALL have port cmd_err, output, 1, one-cycle pulse on a rejected frame.
REQ-010 SHALL have port err_code, output, 2, cause of the last error: 01 checksum, 10 timeout; held until the next error.
REQ-011 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-012 Frame SHALL be: header 0xAA, addr, data_hi, data_lo, chk, where chk = addr XOR data_hi XOR data_lo.
REQ-013 States SHALL be IDLE, ADDR, DHI, DLO, CHK; each accepted byte advances one state.
REQ-014 In IDLE, a byte other than 0xAA SHALL be discarded silently, with no cmd_err pulse.
REQ-015 In CHK, a matching chk SHALL load cmd_addr/cmd_data and pulse cmd_valid in the cycle after the chk strobe, then return to IDLE.
REQ-016 In CHK, a mismatching chk SHALL pulse cmd_err, set err_code=01, leave cmd_addr/cmd_data unchanged, and return to IDLE.
REQ-017 The timeout counter SHALL clear on every accepted byte and increment each cycle while not IDLE.
REQ-018 When the counter reaches TIMEOUT_CYC-1 with no strobe, the block SHALL pulse cmd_err, set err_code=10, and go to IDLE.
REQ-019 If a strobe coincides with timeout expiry, the byte SHALL win: it is accepted and no timeout occurs.
REQ-020 In ADDR/DHI/DLO, 0xAA SHALL be treated as ordinary data; there is no resynchronisation on header.
REQ-021 cmd_valid and cmd_err SHALL never be high in the same cycle.
REQ-022 Back-to-back frames with no idle cycles between strobes SHALL all be accepted.

Reset
REQ-023 While RST_n=1: state=IDLE, counter=0, cmd_addr=0, cmd_data=0, cmd_valid=0, cmd_err=0, err_code=00, busy=0.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame with no pulse on cmd_valid or cmd_err.

Configuration
REQ-025 Macro UART_CMD_CHKSUM_EN defined: 5-byte frame per REQ-012, with CHK state and err_code 01 reachable.
REQ-026 Macro UART_CMD_CHKSUM_EN undefined: 4-byte frame without chk; the DLO byte completes the frame; CHK state and checksum logic are absent; err_code 01 is unreachable.

Structure
REQ-027 Package uart_cmd_pkg SHALL hold the state enum, the HEADER constant 8'hAA, and the err_code constants.
REQ-028 The timeout counter SHALL be sub-module uart_cmd_timeout (inputs clear, run; output expired).

Verification
REQ-029 AA 12 34 56 70 with CHKSUM_EN -> cmd_valid 1 cycle after last strobe, cmd_addr=12, cmd_data=3456.
REQ-030 AA 12 34 56 71 -> cmd_err pulse, err_code=01, cmd_addr/cmd_data keep prior values.
REQ-031 AA 12, then a gap of TIMEOUT_CYC cycles (TIMEOUT_CYC=16) -> cmd_err, err_code=10, busy falls; a following full frame is accepted.
REQ-032 55 00 AA 01 02 03 00 -> leading bytes ignored with no cmd_err; cmd_addr=01, cmd_data=0203.
REQ-033 RST_n pulsed after AA 12 34 -> no pulses, busy=0; the next full frame is decoded correctly.
REQ-034 Without CHKSUM_EN, AA 12 34 56 -> cmd_valid, cmd_addr=12, cmd_data=3456.
